// File: rtl/ula_multiciclo_pkg.sv
// Shared definitions for the multi-cycle ALU: operation codes and the
// iterative unit's state encoding.
package ula_pkg;
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_NOT  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SGT  = 4'b1001;
    localparam logic [3:0] OP_BEQ  = 4'b1010;
    localparam logic [3:0] OP_BNEQ = 4'b1011;
    localparam logic [3:0] OP_SR   = 4'b1100;
    localparam logic [3:0] OP_SL   = 4'b1101;
    localparam logic [3:0] OP_IL0  = 4'b1110;
    localparam logic [3:0] OP_IL1  = 4'b1111;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;
endpackage

// File: rtl/ula_multiciclo_if.sv
// Request/result bundle between the control unit (master) and the ALU (slave).
interface ula_multiciclo_if #(
    parameter int WIDTH = 32
);
    logic             START;
    logic [3:0]       ALUop;
    logic [WIDTH-1:0] D1;
    logic [WIDTH-1:0] D2;
    logic [WIDTH-1:0] RESULTADO;
    logic [WIDTH-1:0] RESTOdiv;
    logic             ZERO;
    logic             BUSY;
    logic             DONE;
    logic             DIV_ZERO;

    modport master (
        output START, ALUop, D1, D2,
        input  RESULTADO, RESTOdiv, ZERO, BUSY, DONE, DIV_ZERO
    );

    modport slave (
        input  START, ALUop, D1, D2,
        output RESULTADO, RESTOdiv, ZERO, BUSY, DONE, DIV_ZERO
    );
endinterface

// File: rtl/ula_multiciclo_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider sharing one
// 2*WIDTH shift register; done/q_lo/r_hi reflect the final iteration's result.
module ula_muldiv_seq
    import ula_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLOCK,
    input  logic             RESET_N,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q_lo,
    output logic [WIDTH-1:0] r_hi
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] FULL = CW'(WIDTH);

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [CW-1:0]      cnt_d;
    logic               is_div_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     trial;

    // MUL: {hi,lo} = {partial product, multiplier}, shifted right each step.
    // DIV: {hi,lo} = {remainder, dividend/quotient}, shifted left each step;
    // trial's MSB set means the subtraction borrowed and is discarded.
    always_comb begin
        sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
        trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};
        acc_d = acc_q;
        if (is_div_q) begin
            if (!trial[WIDTH]) begin
                acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
            end
        end else if (acc_q[0]) begin
            acc_d = {sum, acc_q[WIDTH-1:1]};
        end else begin
            acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
        end
    end

    assign cnt_d = cnt_q + 1'b1;
    assign busy  = (state_q == RUN);
    assign done  = busy && (cnt_d == FULL);
    assign q_lo  = acc_d[WIDTH-1:0];
    assign r_hi  = acc_d[2*WIDTH-1:WIDTH];

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            b_q      <= '0;
            acc_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= RUN;
                        cnt_q    <= '0;
                        is_div_q <= is_div;
                        b_q      <= b;
                        acc_q    <= {{WIDTH{1'b0}}, a};
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    if (cnt_d == FULL) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/ula_multiciclo.sv
// Multi-cycle EX-stage ALU: single-cycle ops computed here, MUL/DIV handed to
// the iterative unit; all results registered and announced with a DONE pulse.
module ula_multiciclo
    import ula_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit SIGNED_CMP = 1'b0
) (
    input  logic             CLOCK,
    input  logic             RESET_N,
    ula_multiciclo_if.slave  bus
);
    logic             seq_busy;
    logic             seq_done;
    logic [WIDTH-1:0] seq_lo;
    logic [WIDTH-1:0] seq_hi;
    logic             accept;
    logic             multi;
    logic             lt;
    logic             gt;

    logic [WIDTH-1:0] res_q,   res_d;
    logic [WIDTH-1:0] resto_q, resto_d;
    logic             zero_q,  zero_d;
    logic             dz_q,    dz_d;
    logic             done_q;

    assign accept = bus.START && !seq_busy;
    // DIV by zero is answered immediately and never enters the iterative unit.
    assign multi  = (bus.ALUop == OP_MUL) || ((bus.ALUop == OP_DIV) && (bus.D2 != '0));
    assign lt     = SIGNED_CMP ? ($signed(bus.D1) < $signed(bus.D2)) : (bus.D1 < bus.D2);
    assign gt     = SIGNED_CMP ? ($signed(bus.D1) > $signed(bus.D2)) : (bus.D1 > bus.D2);

    ula_muldiv_seq #(.WIDTH(WIDTH)) u_seq (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .start   (accept && multi),
        .is_div  (bus.ALUop == OP_DIV),
        .a       (bus.D1),
        .b       (bus.D2),
        .busy    (seq_busy),
        .done    (seq_done),
        .q_lo    (seq_lo),
        .r_hi    (seq_hi)
    );

    always_comb begin
        res_d   = '0;
        resto_d = '0;
        zero_d  = 1'b0;
        dz_d    = 1'b0;
        case (bus.ALUop)
            OP_ADD:  res_d = bus.D1 + bus.D2;
            OP_SUB:  res_d = bus.D1 - bus.D2;
            OP_DIV: begin
                res_d   = '1;
                resto_d = bus.D1;
                dz_d    = 1'b1;
            end
            OP_NOT:  res_d = ~bus.D1;
            OP_AND:  res_d = bus.D1 & bus.D2;
            OP_OR:   res_d = bus.D1 | bus.D2;
            OP_XOR:  res_d = bus.D1 ^ bus.D2;
            OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, lt};
            OP_SGT:  res_d = {{(WIDTH-1){1'b0}}, gt};
            OP_BEQ:  zero_d = (bus.D1 == bus.D2);
            OP_BNEQ: zero_d = (bus.D1 != bus.D2);
            OP_SR:   res_d = bus.D1 >> 1;
            OP_SL:   res_d = bus.D1 << 1;
            default: res_d = '0;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            res_q   <= '0;
            resto_q <= '0;
            zero_q  <= 1'b0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (seq_done) begin
                res_q   <= seq_lo;
                resto_q <= seq_hi;
                zero_q  <= 1'b0;
                dz_q    <= 1'b0;
                done_q  <= 1'b1;
            end else if (accept && !multi) begin
                res_q   <= res_d;
                resto_q <= resto_d;
                zero_q  <= zero_d;
                dz_q    <= dz_d;
                done_q  <= 1'b1;
            end
        end
    end

    assign bus.RESULTADO = res_q;
    assign bus.RESTOdiv  = resto_q;
    assign bus.ZERO      = zero_q;
    assign bus.DIV_ZERO  = dz_q;
    assign bus.DONE      = done_q;
    assign bus.BUSY      = seq_busy;
endmodule

// File: tb/tb_ula_multiciclo.sv
// Scoreboard bench for ula_multiciclo: two instances (signed and unsigned
// compare) share stimulus; a monitor pops expectations on every DONE.
module tb_ula_multiciclo;
    import ula_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [31:0] res;
        logic [31:0] resto;
        logic        zero;
        logic        dz;
        int          lat;
        int          issue;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    int   bc0   = 0;
    int   bc1   = 0;
    exp_t q0[$];
    exp_t q1[$];

    ula_multiciclo_if #(.WIDTH(W)) bus0 ();
    ula_multiciclo_if #(.WIDTH(W)) bus1 ();

    assign bus1.START = bus0.START;
    assign bus1.ALUop = bus0.ALUop;
    assign bus1.D1    = bus0.D1;
    assign bus1.D2    = bus0.D2;

    ula_multiciclo #(.WIDTH(W), .SIGNED_CMP(1'b1)) dut0 (
        .CLOCK(clk), .RESET_N(rst_n), .bus(bus0)
    );
    ula_multiciclo #(.WIDTH(W), .SIGNED_CMP(1'b0)) dut1 (
        .CLOCK(clk), .RESET_N(rst_n), .bus(bus1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference behaviour straight from the operation table, in plain arithmetic.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input bit sgn);
        exp_t e;
        logic [63:0] p;
        e.res = '0; e.resto = '0; e.zero = 1'b0; e.dz = 1'b0; e.lat = 0; e.issue = 0;
        case (op)
            4'd0: e.res = a + b;
            4'd1: e.res = a - b;
            4'd2: begin
                p = {32'b0, a} * {32'b0, b};
                e.res = p[31:0]; e.resto = p[63:32]; e.lat = W;
            end
            4'd3: begin
                if (b == 0) begin
                    e.res = 32'hFFFF_FFFF; e.resto = a; e.dz = 1'b1;
                end else begin
                    e.res = a / b; e.resto = a % b; e.lat = W;
                end
            end
            4'd4:  e.res = ~a;
            4'd5:  e.res = a & b;
            4'd6:  e.res = a | b;
            4'd7:  e.res = a ^ b;
            4'd8:  e.res = sgn ? 32'($signed(a) < $signed(b)) : 32'(a < b);
            4'd9:  e.res = sgn ? 32'($signed(a) > $signed(b)) : 32'(a > b);
            4'd10: e.zero = (a == b);
            4'd11: e.zero = (a != b);
            4'd12: e.res = a >> 1;
            4'd13: e.res = a << 1;
            default: ;
        endcase
        return e;
    endfunction

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e0, e1;
        int guard = 0;
        @(negedge clk);
        while (bus0.BUSY && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) chk("issue_wait_busy", 32'(bus0.BUSY), 32'd0);
        bus0.START = 1'b1; bus0.ALUop = op; bus0.D1 = a; bus0.D2 = b;
        @(posedge clk);
        #1;
        e0 = model(op, a, b, 1'b1); e0.issue = cyc;
        e1 = model(op, a, b, 1'b0); e1.issue = cyc;
        q0.push_back(e0);
        q1.push_back(e1);
        bus0.START = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while ((q0.size() != 0 || q1.size() != 0 || bus0.BUSY) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) chk("drain_timeout", 32'(q0.size()), 32'd0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_res"},   bus0.RESULTADO,      32'd0);
        chk({tag, "_resto"}, bus0.RESTOdiv,       32'd0);
        chk({tag, "_zero"},  32'(bus0.ZERO),      32'd0);
        chk({tag, "_busy"},  32'(bus0.BUSY),      32'd0);
        chk({tag, "_done"},  32'(bus0.DONE),      32'd0);
        chk({tag, "_dz"},    32'(bus0.DIV_ZERO),  32'd0);
    endtask

    // Monitor: every DONE must match the oldest outstanding request.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            bc0 = 0;
            bc1 = 0;
        end else begin
            if (bus0.BUSY) bc0++;
            if (bus1.BUSY) bc1++;
            if (bus0.DONE) begin
                if (q0.size() == 0) begin
                    chk("dut0_done_without_request", 32'(bus0.DONE), 32'd0);
                end else begin
                    e = q0.pop_front();
                    chk("dut0_res",     bus0.RESULTADO,     e.res);
                    chk("dut0_resto",   bus0.RESTOdiv,      e.resto);
                    chk("dut0_zero",    32'(bus0.ZERO),     32'(e.zero));
                    chk("dut0_divzero", 32'(bus0.DIV_ZERO), 32'(e.dz));
                    chk("dut0_latency", cyc - e.issue,      e.lat);
                    chk("dut0_busy_cycles", bc0,            e.lat);
                end
                bc0 = 0;
            end
            if (bus1.DONE) begin
                if (q1.size() == 0) begin
                    chk("dut1_done_without_request", 32'(bus1.DONE), 32'd0);
                end else begin
                    e = q1.pop_front();
                    chk("dut1_res",     bus1.RESULTADO,     e.res);
                    chk("dut1_resto",   bus1.RESTOdiv,      e.resto);
                    chk("dut1_zero",    32'(bus1.ZERO),     32'(e.zero));
                    chk("dut1_divzero", 32'(bus1.DIV_ZERO), 32'(e.dz));
                    chk("dut1_latency", cyc - e.issue,      e.lat);
                    chk("dut1_busy_cycles", bc1,            e.lat);
                end
                bc1 = 0;
            end
        end
    end

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b;
        bus0.START = 1'b0; bus0.ALUop = 4'd0; bus0.D1 = '0; bus0.D2 = '0;

        repeat (2) @(negedge clk);
        chk_outputs_zero("reset");
        #2 rst_n = 1'b1;

        // Directed cases
        issue(OP_ADD,  32'hFFFF_FFFF, 32'd2);
        issue(OP_MUL,  32'hFFFF_FFFF, 32'd2);
        issue(OP_DIV,  32'd100,       32'd7);
        issue(OP_DIV,  32'd5,         32'd0);
        issue(OP_SLT,  32'hFFFF_FFFF, 32'd1);
        issue(OP_SGT,  32'hFFFF_FFFF, 32'd1);
        issue(OP_BEQ,  32'd7,         32'd7);
        issue(OP_BNEQ, 32'd7,         32'd7);
        issue(OP_SUB,  32'd0,         32'd1);
        issue(OP_SR,   32'h8000_0001, 32'd0);
        issue(OP_SL,   32'h8000_0001, 32'd0);
        issue(OP_IL0,  32'h1234_5678, 32'h1);
        issue(OP_IL1,  32'h1234_5678, 32'h1);
        issue(OP_DIV,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(OP_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // START during MUL must be ignored and input changes must not leak in
        issue(OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (5) @(negedge clk);
        bus0.START = 1'b1; bus0.ALUop = OP_ADD; bus0.D1 = 32'h1111_1111; bus0.D2 = 32'h2222_2222;
        @(negedge clk);
        bus0.START = 1'b0; bus0.D1 = 32'hDEAD_0000; bus0.D2 = 32'h0000_BEEF;
        drain();

        // Reset in the middle of a DIV aborts it without a DONE
        issue(OP_DIV, 32'hDEAD_BEEF, 32'h0000_1234);
        repeat (10) @(negedge clk);
        chk("div_busy_before_reset", 32'(bus0.BUSY), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_outputs_zero("midreset");
        q0.delete();
        q1.delete();
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        issue(OP_DIV, 32'd9, 32'd3);
        drain();

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = a;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            issue(op, a, b);
        end
        drain();
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ula_multiciclo.md
Name: ula_multiciclo

Overview:
- Parametrised, multi-cycle successor to the single-cycle ALU of the MIPS-based datapath.
- Logic, compare, shift and add/sub ops complete in 1 cycle. MUL and DIV run iteratively over WIDTH cycles: shift-add multiplier, restoring divider.
- MUL returns a full 2*WIDTH product. DIV flags division by zero.
- Sits in the EX stage. The control unit stalls on BUSY and proceeds on DONE.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4).
- SIGNED_CMP, 0, 1 = SLT/SGT compare two's-complement; 0 = unsigned.

Ports:
- CLOCK  in  1  rising-edge clock
- RESET_N  in  1  asynchronous, active-low reset
- START  in  1  request; sampled only when BUSY=0
- ALUop  in  4  operation code (encoding below)
- D1  in  WIDTH  operand 1
- D2  in  WIDTH  operand 2
- RESULTADO  out  WIDTH  result; MUL low half; DIV quotient
- RESTOdiv  out  WIDTH  DIV remainder; MUL high half; 0 otherwise
- ZERO  out  1  branch condition (BEQ/BNEQ)
- BUSY  out  1  multi-cycle op in progress
- DONE  out  1  one-cycle pulse: outputs valid/updated
- DIV_ZERO  out  1  last DIV had D2=0

Behaviour:
- Reset (RESET_N=0, async): state IDLE, all outputs 0, counter 0, internal registers cleared. Reset mid-operation aborts it; no DONE is produced.
- All outputs are registered. RESULTADO, RESTOdiv, ZERO and DIV_ZERO hold until the next completion. DONE is high for exactly one cycle per accepted START.
- Accept: START=1 and BUSY=0 at edge k. D1, D2 and ALUop are latched; later input changes are ignored. START while BUSY=1 is ignored (no queueing).
- ALUop encoding:
  - 0000 ADD, 0001 SUB, 0010 MUL, 0011 DIV, 0100 NOT(D1), 0101 AND, 0110 OR, 0111 XOR
  - 1000 SLT, 1001 SGT, 1010 BEQ, 1011 BNEQ, 1100 SR (D1>>1 logical), 1101 SL (D1<<1)
  - 1110/1111 illegal: all result outputs 0, DONE still pulses.
- Single-cycle ops: results and DONE=1 at edge k. BUSY stays 0.
  - ADD/SUB wrap modulo 2^WIDTH.
  - SLT/SGT give 1/0, signedness per SIGNED_CMP.
  - BEQ/BNEQ drive ZERO with RESULTADO=0. All other ops drive ZERO=0.
  - RESTOdiv=0 except for MUL/DIV. DIV_ZERO=0 except for DIV.
- State machine: IDLE -> RUN on accepted MUL/DIV with D2!=0. RUN -> IDLE when the counter reaches WIDTH.
- MUL/DIV: BUSY=1 from edge k. The counter performs WIDTH iterations, one per cycle, at edges k+1..k+WIDTH. At edge k+WIDTH: BUSY=0, DONE=1, outputs updated.
  - Latency is WIDTH cycles START-to-DONE. The next START is accepted in the cycle DONE is high.
  - Intermediate values never appear on the outputs.
- MUL is unsigned, product D1*D2 width 2*WIDTH: RESULTADO=product[WIDTH-1:0], RESTOdiv=product[2*WIDTH-1:WIDTH].
- DIV is unsigned, restoring: RESULTADO=floor(D1/D2), RESTOdiv=D1 mod D2, DIV_ZERO=0.
- DIV with D2=0: no iterations, single cycle. At edge k: RESULTADO=all ones, RESTOdiv=D1, DIV_ZERO=1, DONE=1.

Decomposition:
- Package ula_pkg: localparams for the 16 ALUop codes; state enum IDLE/RUN.
- Sub-module ula_muldiv_seq, owning the datapath and counter:
  - Ports: CLOCK, RESET_N, start, is_div, a, b, busy, done, q_lo, r_hi.
  - Contains the shared 2*WIDTH shift register, the counter of $clog2(WIDTH+1) bits, and the add/subtract datapath.
- The top handles decode, single-cycle ops, and output muxing/registering.

Test Plan:
- WIDTH=32. ADD D1=0xFFFFFFFF, D2=2 -> RESULTADO=0x00000001 and DONE one edge after START; BUSY never 1.
- MUL D1=0xFFFFFFFF, D2=2 -> after 32 cycles DONE=1, RESULTADO=0xFFFFFFFE, RESTOdiv=0x00000001; BUSY=1 for exactly 32 cycles.
- DIV 100/7 -> RESULTADO=14, RESTOdiv=2, DIV_ZERO=0 at cycle 32. DIV 5/0 -> next edge RESULTADO=0xFFFFFFFF, RESTOdiv=5, DIV_ZERO=1.
- SLT D1=0xFFFFFFFF, D2=1: SIGNED_CMP=1 -> 1; SIGNED_CMP=0 -> 0. BEQ 7,7 -> ZERO=1; BNEQ 7,7 -> ZERO=0.
- During MUL, pulse START with ADD and change D1/D2 at cycle 5 -> ignored; final MUL result uses the latched operands; exactly one DONE.
- Assert RESET_N=0 mid-DIV (cycle 10) -> outputs 0 immediately, no DONE. After release, a fresh DIV 9/3 -> 3 rem 0.
